// File: rtl/mini_src_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mini_src_ctrl_pkg
//  Purpose  : Shared encodings for the Mini SRC hardwired control unit:
//             opcodes, ALU operation codes, sequencer states and the
//             instruction class produced by the opcode decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package mini_src_ctrl_pkg;

    localparam int unsigned OP_W  = 5;  // opcode field width, IR[31:27]
    localparam int unsigned ALU_W = 5;  // alu_control width

    // Opcodes (IR[31:27])
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // ALU operation selects
    localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_SUB  = 5'b00100;
    localparam logic [ALU_W-1:0] ALU_AND  = 5'b00101;
    localparam logic [ALU_W-1:0] ALU_OR   = 5'b00110;
    localparam logic [ALU_W-1:0] ALU_INC4 = 5'b10111;

    // Sequencer states; T0..T5 are consecutive codes 0111..1100
    typedef enum logic [3:0] {
        S_RST  = 4'b0000,
        T0     = 4'b0111,
        T1     = 4'b1000,
        T2     = 4'b1001,
        T3     = 4'b1010,
        T4     = 4'b1011,
        T5     = 4'b1100,
        S_HALT = 4'b1111
    } state_t;

    // Instruction classes; anything unrecognised decodes as CL_HALT
    typedef enum logic [2:0] {
        CL_RTYPE = 3'd0,
        CL_IMM   = 3'd1,
        CL_MFLO  = 3'd2,
        CL_MFHI  = 3'd3,
        CL_NOP   = 3'd4,
        CL_HALT  = 3'd5
    } op_class_t;

endpackage : mini_src_ctrl_pkg
`default_nettype wire

// File: rtl/mini_src_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mini_src_op_decode
//  Purpose  : Combinational opcode decoder. Maps IR[31:27] to an
//             instruction class and the ALU operation used in T4.
//  Ports    : i_opcode   - opcode field from IR
//             o_op_class - instruction class (RTYPE/IMM/MFLO/MFHI/NOP/HALT)
//             o_alu_op   - ALU select for RTYPE/IMM classes, 0 otherwise
//  Revision : 1.0 - initial release
// ============================================================================
module mini_src_op_decode
    import mini_src_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  i_opcode,
    output op_class_t        o_op_class,
    output logic [ALU_W-1:0] o_alu_op
);

    always_comb begin
        o_op_class = CL_HALT;
        o_alu_op   = '0;
        case (i_opcode)
            OP_ADD:  begin o_op_class = CL_RTYPE; o_alu_op = ALU_ADD; end
            OP_SUB:  begin o_op_class = CL_RTYPE; o_alu_op = ALU_SUB; end
            OP_AND:  begin o_op_class = CL_RTYPE; o_alu_op = ALU_AND; end
            OP_OR:   begin o_op_class = CL_RTYPE; o_alu_op = ALU_OR;  end
            // Immediates reuse the register-form ALU operation
            OP_ADDI: begin o_op_class = CL_IMM;   o_alu_op = ALU_ADD; end
            OP_ANDI: begin o_op_class = CL_IMM;   o_alu_op = ALU_AND; end
            OP_ORI:  begin o_op_class = CL_IMM;   o_alu_op = ALU_OR;  end
            OP_MFLO: o_op_class = CL_MFLO;
            OP_MFHI: o_op_class = CL_MFHI;
            OP_NOP:  o_op_class = CL_NOP;
            OP_HALT: o_op_class = CL_HALT;
            default: o_op_class = CL_HALT;
        endcase
    end

endmodule : mini_src_op_decode
`default_nettype wire

// File: rtl/mini_src_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mini_src_control_unit
//  Purpose  : Hardwired control sequencer for the Mini SRC datapath.
//             Fetch in T0..T2, per-opcode execute in T3..T5, then either
//             the next fetch or HALT. All control outputs are a
//             combinational function of the state and IR[31:27].
//  Ports    : clk          - system clock, rising edge
//             clr          - asynchronous active-high reset
//             ir           - IR contents read back from the datapath
//             stop         - request halt at the next instruction boundary
//             *out / Cout  - bus drivers (at most one high at a time)
//             *en          - register enables
//             Read, Write  - memory strobes (Write is never asserted)
//             Gra..BAout   - register-file select logic
//             alu_control  - ALU operation select
//             run          - high while sequencing, low in HALT
//             state        - current state encoding (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module mini_src_control_unit
    import mini_src_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     ir,
    input  logic            stop,
    output logic            Pout,
    output logic            MDROut,
    output logic            HIout,
    output logic            LOout,
    output logic            ZHIout,
    output logic            ZLOout,
    output logic            Cout,
    output logic            Pen,
    output logic            IRen,
    output logic            MARen,
    output logic            MDRen,
    output logic            Yen,
    output logic            ZHIen,
    output logic            ZLOen,
    output logic            Read,
    output logic            Write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic [ALUW-1:0] alu_control,
    output logic            run,
    output logic [3:0]      state
);

    state_t            state_q, state_d;
    logic              stop_q, stop_d;
    op_class_t         w_class;
    logic [ALU_W-1:0]  w_alu_op;
    logic              w_halt_req;
    logic [OPW-1:0]    w_opcode;

    assign w_opcode = ir[31 -: OPW];

    // Operand fields are consumed by the datapath, not by the sequencer
    logic w_unused_ir;
    assign w_unused_ir = ^ir[31-OPW:0];

    mini_src_op_decode u_op_decode (
        .i_opcode   (OP_W'(w_opcode)),
        .o_op_class (w_class),
        .o_alu_op   (w_alu_op)
    );

    // A stop pulse is remembered until the instruction boundary, so a
    // request made mid-instruction is not lost. Only clr clears it, and
    // the boundary that consumes it enters HALT, which also needs clr.
    assign stop_d     = stop_q | stop;
    assign w_halt_req = stop_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_RST;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = T0;
            T0:    state_d = T1;
            T1:    state_d = T2;
            T2:    state_d = T3;
            T3: begin
                case (w_class)
                    CL_RTYPE, CL_IMM:          state_d = T4;
                    CL_MFLO, CL_MFHI, CL_NOP:  state_d = w_halt_req ? S_HALT : T0;
                    default:                   state_d = S_HALT;
                endcase
            end
            T4:     state_d = T5;
            T5:     state_d = w_halt_req ? S_HALT : T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Control outputs
    always_comb begin
        Pout        = 1'b0;
        MDROut      = 1'b0;
        HIout       = 1'b0;
        LOout       = 1'b0;
        ZHIout      = 1'b0;
        ZLOout      = 1'b0;
        Cout        = 1'b0;
        Pen         = 1'b0;
        IRen        = 1'b0;
        MARen       = 1'b0;
        MDRen       = 1'b0;
        Yen         = 1'b0;
        ZHIen       = 1'b0;
        ZLOen       = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Rin         = 1'b0;
        Rout        = 1'b0;
        BAout       = 1'b0;
        alu_control = '0;
        case (state_q)
            T0: begin
                // MAR <- PC, Z <- PC + 4
                Pout        = 1'b1;
                MARen       = 1'b1;
                ZLOen       = 1'b1;
                alu_control = ALUW'(ALU_INC4);
            end
            T1: begin
                // PC <- Z, MDR <- M[MAR]
                ZLOout = 1'b1;
                Pen    = 1'b1;
                Read   = 1'b1;
                MDRen  = 1'b1;
            end
            T2: begin
                MDROut = 1'b1;
                IRen   = 1'b1;
            end
            T3: begin
                case (w_class)
                    CL_RTYPE, CL_IMM: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yen  = 1'b1;
                    end
                    CL_MFLO: begin
                        LOout = 1'b1;
                        Gra   = 1'b1;
                        Rin   = 1'b1;
                    end
                    CL_MFHI: begin
                        HIout = 1'b1;
                        Gra   = 1'b1;
                        Rin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (w_class)
                    CL_RTYPE: begin
                        Grc         = 1'b1;
                        Rout        = 1'b1;
                        ZLOen       = 1'b1;
                        ZHIen       = 1'b1;
                        alu_control = ALUW'(w_alu_op);
                    end
                    CL_IMM: begin
                        // Immediate comes from the sign-extended C field
                        Cout        = 1'b1;
                        ZLOen       = 1'b1;
                        alu_control = ALUW'(w_alu_op);
                    end
                    default: ;
                endcase
            end
            T5: begin
                if (w_class == CL_RTYPE || w_class == CL_IMM) begin
                    ZLOout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign run   = (state_q != S_HALT);
    assign state = state_q;

endmodule : mini_src_control_unit
`default_nettype wire

// File: tb/tb_mini_src_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mini_src_control_unit
//  Purpose  : Directed self-checking bench for mini_src_control_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mini_src_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        stop;
    logic Pout, MDROut, HIout, LOout, ZHIout, ZLOout, Cout;
    logic Pen, IRen, MARen, MDRen, Yen, ZHIen, ZLOen;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] alu_control;
    logic       run;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mini_src_control_unit #(.OPW(5), .ALUW(5)) dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop),
        .Pout(Pout), .MDROut(MDROut), .HIout(HIout), .LOout(LOout),
        .ZHIout(ZHIout), .ZLOout(ZLOout), .Cout(Cout),
        .Pen(Pen), .IRen(IRen), .MARen(MARen), .MDRen(MDRen),
        .Yen(Yen), .ZHIen(ZHIen), .ZLOen(ZLOen),
        .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_control(alu_control), .run(run), .state(state)
    );

    // Control outputs packed MSB-first in the order below
    logic [21:0] ctrl;
    assign ctrl = {Pout, MDROut, HIout, LOout, ZHIout, ZLOout, Cout,
                   Pen, IRen, MARen, MDRen, Yen, ZHIen, ZLOen,
                   Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

    localparam logic [21:0] C_POUT   = 22'h1 << 21;
    localparam logic [21:0] C_MDROUT = 22'h1 << 20;
    localparam logic [21:0] C_HIOUT  = 22'h1 << 19;
    localparam logic [21:0] C_LOOUT  = 22'h1 << 18;
    localparam logic [21:0] C_ZLOOUT = 22'h1 << 16;
    localparam logic [21:0] C_COUT   = 22'h1 << 15;
    localparam logic [21:0] C_PEN    = 22'h1 << 14;
    localparam logic [21:0] C_IREN   = 22'h1 << 13;
    localparam logic [21:0] C_MAREN  = 22'h1 << 12;
    localparam logic [21:0] C_MDREN  = 22'h1 << 11;
    localparam logic [21:0] C_YEN    = 22'h1 << 10;
    localparam logic [21:0] C_ZHIEN  = 22'h1 << 9;
    localparam logic [21:0] C_ZLOEN  = 22'h1 << 8;
    localparam logic [21:0] C_READ   = 22'h1 << 7;
    localparam logic [21:0] C_GRA    = 22'h1 << 5;
    localparam logic [21:0] C_GRB    = 22'h1 << 4;
    localparam logic [21:0] C_GRC    = 22'h1 << 3;
    localparam logic [21:0] C_RIN    = 22'h1 << 2;
    localparam logic [21:0] C_ROUT   = 22'h1 << 1;

    localparam logic [21:0] E_T0   = C_POUT | C_MAREN | C_ZLOEN;
    localparam logic [21:0] E_T1   = C_ZLOOUT | C_PEN | C_READ | C_MDREN;
    localparam logic [21:0] E_T2   = C_MDROUT | C_IREN;
    localparam logic [21:0] E_ALU3 = C_GRB | C_ROUT | C_YEN;
    localparam logic [21:0] E_R4   = C_GRC | C_ROUT | C_ZLOEN | C_ZHIEN;
    localparam logic [21:0] E_I4   = C_COUT | C_ZLOEN;
    localparam logic [21:0] E_ALU5 = C_ZLOOUT | C_GRA | C_RIN;

    localparam logic [3:0] ST_RST  = 4'b0000;
    localparam logic [3:0] ST_T0   = 4'b0111;
    localparam logic [3:0] ST_T1   = 4'b1000;
    localparam logic [3:0] ST_T2   = 4'b1001;
    localparam logic [3:0] ST_T3   = 4'b1010;
    localparam logic [3:0] ST_T4   = 4'b1011;
    localparam logic [3:0] ST_T5   = 4'b1100;
    localparam logic [3:0] ST_HALT = 4'b1111;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] es, input logic [21:0] ec,
                       input logic [4:0] ea, input logic er);
        total++;
        assert (state === es && ctrl === ec && alu_control === ea && run === er)
        else begin
            bad++;
            $error("FAIL %s: got state=%b ctrl=%h alu=%b run=%b, want state=%b ctrl=%h alu=%b run=%b",
                   tag, state, ctrl, alu_control, run, es, ec, ea, er);
        end
    endtask

    // Checks T1 and T2 (caller has already checked T0)
    task automatic fetch12(input string tag);
        step(); chk({tag, "_T1"}, ST_T1, E_T1, 5'b00000, 1'b1);
        step(); chk({tag, "_T2"}, ST_T2, E_T2, 5'b00000, 1'b1);
    endtask

    initial begin
        clr = 1'b1; ir = 32'h0; stop = 1'b0;

        // Reset held for two cycles
        #1;  chk("rst_async", ST_RST, 22'h0, 5'b00000, 1'b1);
        step(); chk("rst_c1", ST_RST, 22'h0, 5'b00000, 1'b1);
        step(); chk("rst_c2", ST_RST, 22'h0, 5'b00000, 1'b1);
        clr = 1'b0;
        ir  = 32'hC880_0000;                 // MFLO
        step(); chk("mflo_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        fetch12("mflo");
        step(); chk("mflo_T3", ST_T3, C_LOOUT | C_GRA | C_RIN, 5'b00000, 1'b1);

        step(); chk("add_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        ir = 32'h1800_0000;                  // ADD
        fetch12("add");
        step(); chk("add_T3", ST_T3, E_ALU3, 5'b00000, 1'b1);
        step(); chk("add_T4", ST_T4, E_R4, 5'b00011, 1'b1);
        step(); chk("add_T5", ST_T5, E_ALU5, 5'b00000, 1'b1);

        step(); chk("ori_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        ir = 32'h7000_0000;                  // ORI
        fetch12("ori");
        step(); chk("ori_T3", ST_T3, E_ALU3, 5'b00000, 1'b1);
        step(); chk("ori_T4", ST_T4, E_I4, 5'b00110, 1'b1);
        step(); chk("ori_T5", ST_T5, E_ALU5, 5'b00000, 1'b1);

        step(); chk("andi_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        ir = 32'h6800_0000;                  // ANDI
        fetch12("andi");
        step(); chk("andi_T3", ST_T3, E_ALU3, 5'b00000, 1'b1);
        step(); chk("andi_T4", ST_T4, E_I4, 5'b00101, 1'b1);
        step(); chk("andi_T5", ST_T5, E_ALU5, 5'b00000, 1'b1);

        step(); chk("sub_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        ir = 32'h2000_0000;                  // SUB, stop pulsed during T4
        fetch12("sub");
        step(); chk("sub_T3", ST_T3, E_ALU3, 5'b00000, 1'b1);
        step(); chk("sub_T4", ST_T4, E_R4, 5'b00100, 1'b1);
        stop = 1'b1;
        step(); chk("sub_T5", ST_T5, E_ALU5, 5'b00000, 1'b1);
        stop = 1'b0;
        step(); chk("stop_halt", ST_HALT, 22'h0, 5'b00000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); chk("stop_hold", ST_HALT, 22'h0, 5'b00000, 1'b0);
        end

        // Leave HALT through clr
        #2; clr = 1'b1;
        #1; chk("halt_clr", ST_RST, 22'h0, 5'b00000, 1'b1);
        step(); clr = 1'b0;
        ir = 32'hC000_0000;                  // MFHI
        step(); chk("mfhi_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        fetch12("mfhi");
        step(); chk("mfhi_T3", ST_T3, C_HIOUT | C_GRA | C_RIN, 5'b00000, 1'b1);

        step(); chk("nop_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        ir = 32'hD000_0000;                  // NOP
        fetch12("nop");
        step(); chk("nop_T3", ST_T3, 22'h0, 5'b00000, 1'b1);

        step(); chk("clr4_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        ir = 32'h1800_0000;                  // ADD, reset at T4
        fetch12("clr4");
        step(); chk("clr4_T3", ST_T3, E_ALU3, 5'b00000, 1'b1);
        step(); chk("clr4_T4", ST_T4, E_R4, 5'b00011, 1'b1);
        #2; clr = 1'b1;
        #1; chk("clr4_async", ST_RST, 22'h0, 5'b00000, 1'b1);
        step(); chk("clr4_hold", ST_RST, 22'h0, 5'b00000, 1'b1);
        clr = 1'b0;
        step(); chk("clr4_reT0", ST_T0, E_T0, 5'b10111, 1'b1);
        fetch12("clr4_re");
        step(); chk("clr4_reT3", ST_T3, E_ALU3, 5'b00000, 1'b1);
        step(); chk("clr4_reT4", ST_T4, E_R4, 5'b00011, 1'b1);
        step(); chk("clr4_reT5", ST_T5, E_ALU5, 5'b00000, 1'b1);

        step(); chk("undef_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        ir = 32'hF800_0000;                  // undefined opcode 11111
        fetch12("undef");
        step(); chk("undef_T3", ST_T3, 22'h0, 5'b00000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(); chk("undef_halt", ST_HALT, 22'h0, 5'b00000, 1'b0);
        end

        // Explicit HALT opcode
        #2; clr = 1'b1;
        step(); clr = 1'b0;
        ir = 32'hD800_0000;
        step(); chk("halt_T0", ST_T0, E_T0, 5'b10111, 1'b1);
        fetch12("halt");
        step(); chk("halt_T3", ST_T3, 22'h0, 5'b00000, 1'b1);
        step(); chk("halt_st", ST_HALT, 22'h0, 5'b00000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mini_src_control_unit
`default_nettype wire
